piezo_tone_seq: RTL
===================

PIEZO_TONE_SEQ -- requirements
Module: piezo_tone_seq

Interface
REQ-001 SHALL have parameter N_KEYS, default 8: number of one-hot key inputs and note-table entries.
REQ-002 SHALL have parameter CNT_W, default 12: tone counter width.
REQ-003 SHALL have parameter DEPTH, default 16: note buffer entries, a power of two.
REQ-004 SHALL have parameter NOTE_TICKS, default 25_000_000: playback clocks per note.
REQ-005 SHALL have parameter GAP_TICKS, default 2_500_000: silent clocks between played notes.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port btn, input, N_KEYS: key inputs.
REQ-009 SHALL have port octave, input, 2: octave shift, 0 to 3.
REQ-010 SHALL have port rec, input, 1: record enable (level).
REQ-011 SHALL have port play, input, 1: playback request, one-cycle pulse.
REQ-012 SHALL have port piezo, output, 1: square-wave drive.
REQ-013 SHALL have port busy, output, 1: high during playback.
REQ-014 SHALL have port count, output, clog2(DEPTH)+1: notes stored.

Function
REQ-015 SHALL select the active key as the lowest set btn bit; btn==0 means silence.
REQ-016 SHALL compute half-period H = (TABLE[key] >> 1) >> octave, truncated to CNT_W.
REQ-017 Tone SHALL increment cnt each cycle; when cnt >= H it SHALL toggle piezo and clear cnt, giving a period of 2*(H+1) clocks.
REQ-018 A change of active note or octave SHALL clear cnt the next cycle and leave the piezo level unchanged.
REQ-019 On silence, piezo and cnt SHALL be forced to 0 the next cycle.
REQ-020 FSM states SHALL be IDLE, REC, PLAY_NOTE and PLAY_GAP.
REQ-021 IDLE/REC: SHALL play live keys; REC/PLAY btn SHALL be ignored in PLAY states.
REQ-022 IDLE with rec=1 SHALL go to REC and clear count to 0; rec SHALL take priority over a simultaneous play.
REQ-023 In REC, each btn transition from 0 to nonzero SHALL write the key index at address count and increment count.
REQ-024 In REC with count==DEPTH, further presses SHALL be dropped; live tone SHALL continue.
REQ-025 REC with rec=0 SHALL return to IDLE; the buffer SHALL be retained.
REQ-026 IDLE with play=1 and count>0 SHALL enter PLAY_NOTE at index 0 with busy=1 on the next cycle.
REQ-027 play SHALL be ignored when count==0 and in REC.
REQ-028 PLAY_NOTE SHALL sound the stored note for exactly NOTE_TICKS cycles, then go to PLAY_GAP.
REQ-029 PLAY_GAP SHALL hold piezo at 0 for GAP_TICKS cycles, then advance the index.
REQ-030 After the last note (index count-1), PLAY_GAP SHALL go to IDLE with busy=0.
REQ-031 rec and play SHALL be ignored during PLAY states.

Reset
REQ-032 While rst=0 at a clock edge: state IDLE, piezo=0, busy=0, count=0, cnt=0, all timers=0; buffer contents need not be cleared.
REQ-033 Reset mid-playback or mid-record SHALL abort at that edge with no further output toggle.

Configuration
REQ-034 Macro PIEZO_GAP_EN defined: PLAY_GAP SHALL exist as specified.
REQ-035 Macro PIEZO_GAP_EN undefined: PLAY_NOTE SHALL advance directly to the next note, GAP_TICKS SHALL be unused, and notes SHALL be contiguous.

Structure
REQ-036 Package piezo_pkg SHALL hold the state enum and the note table {3830,3400,3038,2864,2550,2272,2028,1912} full-period counts (C2..C3), indexed 0..7.
REQ-037 Sub-module piezo_tone_gen SHALL implement REQ-016..REQ-019, taking inputs en, key index and octave.

Verification (N_KEYS=8, DEPTH=4, NOTE_TICKS=100, GAP_TICKS=20)
REQ-038 btn=8'h01, octave=0 -> piezo toggles every 1916 clocks; octave=1 -> every 958.
REQ-039 btn=8'h05 -> C2 (toggle 1916); switch to 8'h02 -> cnt restarts, toggles every 1701.
REQ-040 rec=1, press keys 2,4,6,7,0 -> count=4 and the fifth press is dropped; then rec=0 and play pulse -> busy=1, four 100-clock tones E2,G2,B2,C3 with 20-clock zero gaps, then busy=0.
REQ-041 rst=0 at clock 150 of playback -> next edge piezo=0, busy=0, count=0.
REQ-042 play with count=0 -> no state change; rec and play in the same cycle -> REC entered.

Source files
------------

// File: rtl/piezo_pkg.sv
// Shared types and note data for the piezo tone sequencer: FSM state encoding
// and the full-period note table (C2..C3, clocks per full cycle).
package piezo_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REC       = 2'd1,
        PLAY_NOTE = 2'd2,
        PLAY_GAP  = 2'd3
    } state_t;

    localparam int NOTE_CNT = 8;

    localparam logic [15:0] NOTE_TABLE [NOTE_CNT] = '{
        16'd3830, 16'd3400, 16'd3038, 16'd2864,
        16'd2550, 16'd2272, 16'd2028, 16'd1912
    };

    // Keys beyond the table map to a zero period rather than aliasing onto it.
    function automatic logic [15:0] note_full(input logic [7:0] idx);
        if (idx >= 8'(NOTE_CNT)) begin
            return '0;
        end
        return NOTE_TABLE[idx[2:0]];
    endfunction

endpackage

// File: rtl/piezo_tone_gen.sv
// Square-wave generator: half-period from the note table shifted by octave,
// counter restart on note/octave change, forced low while disabled.
module piezo_tone_gen
    import piezo_pkg::*;
#(
    parameter int CNT_W = 12,
    parameter int KW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [KW-1:0] key,
    input  logic [1:0]    octave,
    output logic          piezo
);

    logic [15:0]      full_per;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt;
    logic [KW-1:0]    key_q;
    logic [1:0]       oct_q;
    logic             en_q;

    always_comb begin
        full_per = note_full(8'(key));
        half     = CNT_W'((full_per >> 1) >> octave);
    end

    // A change only counts while the tone was already running; starting from
    // silence simply begins counting from the cleared state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            piezo <= 1'b0;
            cnt   <= '0;
            key_q <= '0;
            oct_q <= '0;
            en_q  <= 1'b0;
        end else begin
            en_q  <= en;
            key_q <= key;
            oct_q <= octave;
            if (!en) begin
                piezo <= 1'b0;
                cnt   <= '0;
            end else if (en_q && ((key != key_q) || (octave != oct_q))) begin
                cnt <= '0;
            end else if (cnt >= half) begin
                piezo <= ~piezo;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/piezo_tone_seq.sv
// Piezo keyboard with record/playback buffer. Define PIEZO_GAP_EN to insert a
// silent PLAY_GAP between played notes; otherwise notes play back to back.
//
//   state     | meaning
//   IDLE      | live keys sound, waiting for rec or play
//   REC       | live keys sound, each new press is stored
//   PLAY_NOTE | stored note at idx sounds for NOTE_TICKS clocks
//   PLAY_GAP  | silence for GAP_TICKS clocks before the next note
module piezo_tone_seq
    import piezo_pkg::*;
#(
    parameter int N_KEYS     = 8,
    parameter int CNT_W      = 12,
    parameter int DEPTH      = 16,
    parameter int NOTE_TICKS = 25_000_000,
    parameter int GAP_TICKS  = 2_500_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_KEYS-1:0]       btn,
    input  logic [1:0]              octave,
    input  logic                    rec,
    input  logic                    play,
    output logic                    piezo,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int KW    = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int TMR_W = $clog2(((NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS) + 1);

    localparam logic [AW:0]      DEPTH_C   = (AW + 1)'(DEPTH);
    localparam logic [TMR_W-1:0] NOTE_LOAD = TMR_W'(NOTE_TICKS - 1);
`ifdef PIEZO_GAP_EN
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_TICKS - 1);
`endif

    state_t            state, state_nxt;
    logic [TMR_W-1:0]  timer, timer_nxt;
    logic [AW-1:0]     idx, idx_nxt;
    logic [AW:0]       count_nxt;
    logic              wr_en;
    logic              btn_q;
    logic              btn_rise;
    logic              last_note;
    logic [KW-1:0]     live_key;
    logic [KW-1:0]     tone_key;
    logic              tone_en;
    logic [KW-1:0]     note_buf [DEPTH];

    // Descending scan so the lowest set key wins.
    always_comb begin
        live_key = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (btn[i]) begin
                live_key = KW'(i);
            end
        end
    end

    assign btn_rise  = (|btn) && !btn_q;
    assign last_note = ({1'b0, idx} == (count - 1'b1));
    assign busy      = (state == PLAY_NOTE) || (state == PLAY_GAP);

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        idx_nxt   = idx;
        count_nxt = count;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (rec) begin
                    state_nxt = REC;
                    count_nxt = '0;
                end else if (play && (count != '0)) begin
                    state_nxt = PLAY_NOTE;
                    idx_nxt   = '0;
                    timer_nxt = NOTE_LOAD;
                end
            end
            REC: begin
                if (!rec) begin
                    state_nxt = IDLE;
                end else if (btn_rise && (count < DEPTH_C)) begin
                    wr_en     = 1'b1;
                    count_nxt = count + 1'b1;
                end
            end
            PLAY_NOTE: begin
                if (timer != '0) begin
                    timer_nxt = timer - 1'b1;
                end else begin
`ifdef PIEZO_GAP_EN
                    state_nxt = PLAY_GAP;
                    timer_nxt = GAP_LOAD;
`else
                    if (last_note) begin
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        timer_nxt = NOTE_LOAD;
                    end
`endif
                end
            end
            PLAY_GAP: begin
                if (timer != '0) begin
                    timer_nxt = timer - 1'b1;
                end else if (last_note) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = PLAY_NOTE;
                    idx_nxt   = idx + 1'b1;
                    timer_nxt = NOTE_LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            timer <= '0;
            idx   <= '0;
            count <= '0;
            btn_q <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            idx   <= idx_nxt;
            count <= count_nxt;
            btn_q <= |btn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            note_buf[count[AW-1:0]] <= live_key;
        end
    end

    always_comb begin
        tone_en  = 1'b0;
        tone_key = live_key;
        case (state)
            IDLE, REC: begin
                tone_en  = |btn;
                tone_key = live_key;
            end
            PLAY_NOTE: begin
                tone_en  = 1'b1;
                tone_key = note_buf[idx];
            end
            default: begin
                tone_en  = 1'b0;
                tone_key = live_key;
            end
        endcase
    end

    piezo_tone_gen #(
        .CNT_W (CNT_W),
        .KW    (KW)
    ) u_tone (
        .clk    (clk),
        .rst    (rst),
        .en     (tone_en),
        .key    (tone_key),
        .octave (octave),
        .piezo  (piezo)
    );

endmodule
